// File: rtl/gcd_share_pkg.sv
// gcd_share_pkg
//   Shared definitions for the gcd core arbiter (gcd_share_ctrl).
//   - FSM state encoding: ST_IDLE / ST_LOAD / ST_RUN / ST_RESP
//   - GCD_WIDTH: default operand/result width
//   - rr_wrap(): modular add used by the round-robin logic
//   Optional feature macro used by the top: GCD_SHARE_TIMEOUT_EN
package gcd_share_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam int unsigned GCD_WIDTH = 8;

  // (base + off) mod n, for base < n and off < n; avoids a real divider.
  function automatic int unsigned rr_wrap(input int unsigned base,
                                          input int unsigned off,
                                          input int unsigned n);
    int unsigned s;
    s = base + off;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/gcd_share_ctrl_rr_pick.sv
// rr_pick
//   Combinational round-robin picker: selects the first asserted request
//   at or after ptr, wrapping around.
//   Ports:
//     req   in  N_REQ  request vector
//     ptr   in  IDX_W  highest-priority index
//     grant out N_REQ  one-hot grant (zero when no request)
//     idx   out IDX_W  binary index of grant
//     any   out 1      at least one request present
module rr_pick
  import gcd_share_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int unsigned cand;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = rr_wrap(32'(ptr), i, N_REQ);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/gcd_share_ctrl.sv
// gcd_share_ctrl
//   Shares one iterative gcd core among N_REQ requesters. Requests are
//   granted round-robin, one operation in flight at a time.
//   Handshake: a requester holds req_valid[i] with stable operands until it
//   sees the one-cycle req_ready[i] pulse; its operands were captured on the
//   clock edge that raised req_ready. The result comes back as a one-cycle
//   rsp_valid[i] pulse with rsp_y/rsp_err; there is no response backpressure.
//   Ports:
//     clock, reset          system clock, synchronous active-high reset
//     req_valid/req_a/req_b per-requester request, operands packed WIDTH each
//     req_ready             one-hot capture pulse
//     rsp_valid/rsp_y/rsp_err one-hot result pulse, shared result bus, error
//     core_load/core_a/core_b drive the gcd core (load=1 loads, 0 iterates)
//     core_y/core_ready     core result and its valid flag
//   Optional feature: define GCD_SHARE_TIMEOUT_EN to add a RUN watchdog of
//   TIMEOUT_CYC cycles that returns rsp_y=0 with rsp_err=1.
module gcd_share_ctrl
  import gcd_share_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = GCD_WIDTH
`ifdef GCD_SHARE_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 64
`endif
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]       rsp_y,
  output logic                   rsp_err,
  output logic                   core_load,
  output logic [WIDTH-1:0]       core_a,
  output logic [WIDTH-1:0]       core_b,
  input  logic [WIDTH-1:0]       core_y,
  input  logic                   core_ready
);

  localparam int unsigned      IDX_W    = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  logic [1:0]       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] g_idx;
  logic             blank;   // high during the first RUN cycle

  logic [N_REQ-1:0] pick_grant;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign sel_a = req_a[pick_idx*WIDTH +: WIDTH];
  assign sel_b = req_b[pick_idx*WIDTH +: WIDTH];

`ifdef GCD_SHARE_TIMEOUT_EN
  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] run_cnt;
  logic             err_q;
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      g_idx     <= '0;
      blank     <= 1'b0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_y     <= '0;
      core_load <= 1'b1;
      core_a    <= '0;
      core_b    <= '0;
`ifdef GCD_SHARE_TIMEOUT_EN
      run_cnt   <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      case (state)
        ST_IDLE: begin
          core_load <= 1'b1;
          if (pick_any) begin
            req_ready <= pick_grant;
            g_idx     <= pick_idx;
`ifdef GCD_SHARE_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
            // A zero operand makes the answer the other operand
            // (gcd(0,0)=0), so the core is not used at all.
            if (sel_a == '0 || sel_b == '0) begin
              rsp_y <= sel_a | sel_b;
              state <= ST_RESP;
            end else begin
              core_a <= sel_a;
              core_b <= sel_b;
              state  <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          core_load <= 1'b0;
          blank     <= 1'b1;
`ifdef GCD_SHARE_TIMEOUT_EN
          run_cnt   <= '0;
`endif
          state     <= ST_RUN;
        end
        ST_RUN: begin
          blank <= 1'b0;
          // core_ready may still reflect the previous operation during the
          // first RUN cycle, so it is only trusted once blank has cleared.
          if (!blank && core_ready) begin
            rsp_y     <= core_y;
            core_load <= 1'b1;
            state     <= ST_RESP;
          end
`ifdef GCD_SHARE_TIMEOUT_EN
          else if (run_cnt == RUN_LAST) begin
            rsp_y     <= '0;
            err_q     <= 1'b1;
            core_load <= 1'b1;
            state     <= ST_RESP;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          rsp_valid <= ONE_HOT0 << g_idx;
          rr_ptr    <= IDX_W'(rr_wrap(32'(g_idx), 1, N_REQ));
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_share_ctrl.sv
// tb_gcd_share_ctrl
//   Directed bench for gcd_share_ctrl (N_REQ=4, WIDTH=8) with a behavioural
//   gcd core whose ready latency is programmable. Inputs are driven and
//   outputs sampled on the falling clock edge.
//   With GCD_SHARE_TIMEOUT_EN defined the DUT is built with TIMEOUT_CYC=8
//   and the watchdog case is exercised.
module tb_gcd_share_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_y;
  logic        rsp_err;
  logic        core_load;
  logic [7:0]  core_a;
  logic [7:0]  core_b;
  logic [7:0]  core_y;
  logic        core_ready;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] exp_q[$];

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  gcd_share_ctrl #(
    .N_REQ (4),
    .WIDTH (8)
`ifdef GCD_SHARE_TIMEOUT_EN
    , .TIMEOUT_CYC (8)
`endif
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_y      (rsp_y),
    .rsp_err    (rsp_err),
    .core_load  (core_load),
    .core_a     (core_a),
    .core_b     (core_b),
    .core_y     (core_y),
    .core_ready (core_ready)
  );

  // ---------------- core model ----------------
  // core_ready rises once core_load has been low for core_lat full cycles.
  int core_cnt = 0;
  int core_lat = 1;
  bit core_en  = 1'b1;

  function automatic logic [7:0] gcd_f(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x, y, t;
    x = a;
    y = b;
    for (int i = 0; i < 64 && y != 0; i++) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  always @(posedge clock) begin
    if (core_load) core_cnt <= 0;
    else           core_cnt <= core_cnt + 1;
  end

  assign core_ready = core_en && !core_load && (core_cnt >= core_lat);
  always_comb core_y = gcd_f(core_a, core_b);

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int i);
    logic [3:0] v;
    v = 4'b0001;
    return v << i;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive(input int r, input logic [7:0] a, input logic [7:0] b);
    req_a[r*8 +: 8] = a;
    req_b[r*8 +: 8] = b;
    req_valid[r]    = 1'b1;
  endtask

  task automatic wait_grant(input string tag, input logic [3:0] exp_oh);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (req_ready == 4'b0 && n < 50);
    check(tag, {28'b0, req_ready}, {28'b0, exp_oh});
  endtask

  task automatic wait_rsp(input string tag, input logic [3:0] exp_oh,
                          input logic [7:0] exp_y, input logic exp_err,
                          output int lat, output int low_cnt);
    int n;
    bit both;
    n = 0;
    low_cnt = 0;
    both = 1'b0;
    do begin
      @(negedge clock);
      n++;
      if (!core_load) low_cnt++;
      if (req_ready != 4'b0 && rsp_valid != 4'b0) both = 1'b1;
    end while (rsp_valid == 4'b0 && n < 300);
    check({tag, "_vld"}, {28'b0, rsp_valid}, {28'b0, exp_oh});
    check({tag, "_y"}, {24'b0, rsp_y}, {24'b0, exp_y});
    check({tag, "_err"}, {31'b0, rsp_err}, {31'b0, exp_err});
    check({tag, "_excl"}, {31'b0, both}, 32'd0);
    lat = n;
  endtask

  // Single request from idle; exp_lat counts cycles from req_ready to rsp_valid.
  task automatic do_req(input string tag, input int r, input logic [7:0] a,
                        input logic [7:0] b, input int clat, input int exp_lat,
                        input logic [7:0] exp_y, input logic exp_err);
    int lat, low;
    bit byp;
    byp = (a == 8'd0) || (b == 8'd0);
    core_lat = clat;
    drive(r, a, b);
    wait_grant({tag, "_grant"}, oh(r));
    req_valid[r] = 1'b0;
    check({tag, "_ld_at_grant"}, {31'b0, core_load}, 32'd1);
    if (!byp) begin
      check({tag, "_core_a"}, {24'b0, core_a}, {24'b0, a});
      check({tag, "_core_b"}, {24'b0, core_b}, {24'b0, b});
    end
    wait_rsp(tag, oh(r), exp_y, exp_err, lat, low);
    check({tag, "_lat"}, lat, exp_lat);
    // core_load is low for every RUN cycle and nothing else
    check({tag, "_run_cycles"}, low, byp ? 0 : exp_lat - 2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, low, grants, resps, n, seen;
    int order[5];
    logic [7:0] ys[4];
    order = '{0, 1, 2, 3, 0};
    ys    = '{8'd4, 8'd5, 8'd7, 8'd3};

    reset     = 1'b1;
    req_valid = 4'b0;
    req_a     = 32'b0;
    req_b     = 32'b0;
    repeat (2) @(negedge clock);

    // Requests present while still in reset: nothing may be granted.
    drive(1, 8'd9, 8'd5);
    drive(3, 8'd12, 8'd12);
    @(negedge clock);
    check("rst_req_ready", {28'b0, req_ready}, 32'd0);
    check("rst_rsp_valid", {28'b0, rsp_valid}, 32'd0);
    check("rst_rsp_y", {24'b0, rsp_y}, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst_core_load", {31'b0, core_load}, 32'd1);
    check("rst_core_a", {24'b0, core_a}, 32'd0);
    check("rst_core_b", {24'b0, core_b}, 32'd0);
    reset = 1'b0;

    // req1 and req3 together from reset: req1 first, then req3.
    core_lat = 1;
    wait_grant("pair_g1", 4'b0010);
    req_valid[1] = 1'b0;
    wait_rsp("pair_r1", 4'b0010, 8'd1, 1'b0, lat, low);
    wait_grant("pair_g3", 4'b1000);
    req_valid[3] = 1'b0;
    wait_rsp("pair_r3", 4'b1000, 8'd12, 1'b0, lat, low);

    // All four held valid: pointer wrapped to 0, so order 0,1,2,3,0.
    core_lat = 0;
    drive(0, 8'd8, 8'd12);
    drive(1, 8'd15, 8'd10);
    drive(2, 8'd7, 8'd21);
    drive(3, 8'd9, 8'd6);
    grants = 0;
    resps  = 0;
    n      = 0;
    while (resps < 5 && n < 300) begin
      @(negedge clock);
      n++;
      if (req_ready != 4'b0 && grants < 5) begin
        check($sformatf("rr_grant%0d", grants), {28'b0, req_ready}, {28'b0, oh(order[grants])});
        exp_q.push_back(ys[order[grants]]);
        grants++;
        if (grants == 5) req_valid = 4'b0;
      end
      if (rsp_valid != 4'b0) begin
        if (exp_q.size() == 0) begin
          check("rr_spurious_rsp", {28'b0, rsp_valid}, 32'd0);
        end else begin
          check($sformatf("rr_rsp_vld%0d", resps), {28'b0, rsp_valid}, {28'b0, oh(order[resps])});
          check($sformatf("rr_rsp_y%0d", resps), {24'b0, rsp_y}, {24'b0, exp_q.pop_front()});
        end
        resps++;
      end
    end
    check("rr_resp_count", resps, 5);

    // Basic core path: ready after 4 RUN cycles, response 7 cycles after grant.
    do_req("basic", 0, 8'd12, 8'd18, 4, 7, 8'd6, 1'b0);
    // Ready held high: the first RUN cycle must be ignored.
    do_req("blank", 3, 8'd21, 8'd14, 0, 4, 8'd7, 1'b0);
    // Zero operands bypass the core.
    do_req("byp_0_7", 2, 8'd0, 8'd7, 1, 1, 8'd7, 1'b0);
    do_req("byp_0_0", 2, 8'd0, 8'd0, 1, 1, 8'd0, 1'b0);
    do_req("byp_5_0", 3, 8'd5, 8'd0, 1, 1, 8'd5, 1'b0);

    // Reset while req0 is in RUN: transfer abandoned, no response.
    core_lat = 20;
    drive(0, 8'd6, 8'd2);
    wait_grant("abort_grant", 4'b0001);
    req_valid[0] = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("abort_req_ready", {28'b0, req_ready}, 32'd0);
    check("abort_rsp_valid", {28'b0, rsp_valid}, 32'd0);
    check("abort_rsp_y", {24'b0, rsp_y}, 32'd0);
    check("abort_core_load", {31'b0, core_load}, 32'd1);
    check("abort_core_a", {24'b0, core_a}, 32'd0);
    check("abort_core_b", {24'b0, core_b}, 32'd0);
    reset = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clock);
      if (rsp_valid != 4'b0) seen++;
    end
    check("abort_no_rsp", seen, 0);
    do_req("rereq", 0, 8'd6, 8'd2, 2, 5, 8'd2, 1'b0);

`ifdef GCD_SHARE_TIMEOUT_EN
    // Core never ready: watchdog fires after 8 RUN cycles.
    core_en = 1'b0;
    do_req("tmo", 1, 8'd10, 8'd4, 1, 10, 8'd0, 1'b1);
    core_en = 1'b1;
    do_req("tmo_next", 1, 8'd10, 8'd4, 1, 4, 8'd2, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
